// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped countdown timer:
// register word offsets, CTRL bit positions, mode codes and FSM state encoding.
package timer_counter_pkg;

   // Word offsets on the bus
   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] ADDR_UNUSED = 2'd3;

   // CTRL bit positions
   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_MODE_MSB = 2;
   localparam int CTRL_IM_BIT   = 3;
   localparam int CTRL_W        = 4;

   // Mode codes; codes 2 and 3 fall back to one-shot behaviour
   localparam logic [1:0] MODE_ONESHOT = 2'd0;
   localparam logic [1:0] MODE_RELOAD  = 2'd1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   function automatic logic is_reload(input logic [1:0] mode);
      return (mode == MODE_RELOAD);
   endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with interrupt.
// Counts down from PRESET and flags an interrupt at zero. Mode 0 is one-shot
// with a held flag, mode 1 auto-reloads and pulses the flag for one cycle.
//
// Ports
//   Clk   in   1   system clock, rising edge
//   Rst   in   1   asynchronous active-low reset
//   Addr  in   2   word offset: 0 CTRL, 1 PRESET, 2 COUNT, 3 unused
//   We    in   1   write strobe, sampled at posedge Clk
//   Din   in   32  write data
//   Dout  out  32  combinational read data for Addr
//   IRQ   out  1   interrupt request = irq_flag & CTRL.IM
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | stopped; waits for CTRL.Enable
// LOAD    | copies PRESET into COUNT
// CNT     | decrements COUNT; terminal count raises irq_flag
// INT     | one-shot: clears Enable and stops; reload: drops flag, reloads
module timer_counter
   import timer_counter_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [1:0]  Addr,
   input  logic        We,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t             state_q, state_d;
   logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
   logic [CNT_W-1:0]   preset_q, preset_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               irq_flag_q, irq_flag_d;

   logic               enable;
   logic [1:0]         mode;
   logic               irq_mask;

   assign enable   = ctrl_q[CTRL_EN_BIT];
   assign mode     = ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB];
   assign irq_mask = ctrl_q[CTRL_IM_BIT];

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q    <= ST_IDLE;
         ctrl_q     <= '0;
         preset_q   <= '0;
         count_q    <= '0;
         irq_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         irq_flag_q <= irq_flag_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      irq_flag_d = irq_flag_q;

      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            count_d = preset_q;
            state_d = ST_CNT;
         end
         ST_CNT: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (count_q > CNT_ONE) begin
               count_d = count_q - CNT_ONE;
            end else begin
               // covers COUNT==1 and a zero PRESET; COUNT never wraps
               count_d    = '0;
               irq_flag_d = 1'b1;
               state_d    = ST_INT;
            end
         end
         ST_INT: begin
            if (is_reload(mode)) begin
               irq_flag_d = 1'b0;
               state_d    = ST_LOAD;
            end else begin
               ctrl_d[CTRL_EN_BIT] = 1'b0;
               state_d             = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Bus writes override the FSM for the register being written.
      // LOAD above has already sampled the old PRESET.
      if (We) begin
         case (Addr)
            ADDR_CTRL: begin
               ctrl_d     = Din[CTRL_W-1:0];
               state_d    = ST_IDLE;
               irq_flag_d = 1'b0;
            end
            ADDR_PRESET: begin
               preset_d   = Din[CNT_W-1:0];
               irq_flag_d = 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign Dout = (Addr == ADDR_CTRL)   ? {{(32-CTRL_W){1'b0}}, ctrl_q} :
                 (Addr == ADDR_PRESET) ? 32'(preset_q) :
                 (Addr == ADDR_COUNT)  ? 32'(count_q)  :
                                         32'd0;

   assign IRQ = irq_flag_q & irq_mask;

endmodule
